// File: rtl/yd_dbus_resp.sv
// yd_dbus_resp
//   Responder end of the core data bus. It decodes the 16-bit word address into
//   data RAM (0 .. 2**RAM_AW-1) and a 16-word I/O page at MMIO_BASE. The I/O
//   page holds the GPIO registers and an optional prescaled 16-bit timer.
//   Every cycle is a read. d_dout is registered, so it holds the data for the
//   address presented in the previous cycle. A write and a read of the same
//   address in one cycle return the old value.
//
//   Build option: define YD_DBUS_TIMER_EN to implement the timer registers
//   (offsets 2-5) and tmr_irq. Without it, those offsets read 0 and ignore
//   writes, tmr_irq is tied low, and no timer state exists.
//
// Ports
//   clk      in   1       clock, rising edge
//   rst_n    in   1       asynchronous reset, active low
//   d_addr   in   16      word address, valid every cycle
//   d_din    in   16      write data
//   d_we     in   1       write strobe
//   d_dout   out  16      registered read data
//   gpio_i   in   GPIO_W  asynchronous inputs (synchronized internally)
//   gpio_o   out  GPIO_W  general-purpose outputs
//   tmr_irq  out  1       timer interrupt, level

module yd_dbus_resp #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hFF00,
  parameter int          GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       d_addr,
  input  logic [15:0]       d_din,
  input  logic              d_we,
  output logic [15:0]       d_dout,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              tmr_irq
);

  localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
  localparam logic [3:0] OFF_TMR_CTRL = 4'd2;
  localparam logic [3:0] OFF_TMR_CNT  = 4'd3;
  localparam logic [3:0] OFF_TMR_RLD  = 4'd4;
  localparam logic [3:0] OFF_TMR_STAT = 4'd5;

  logic [15:0]       ram [2**RAM_AW];
  logic              ram_sel;
  logic              io_sel;
  logic [3:0]        io_off;
  logic              io_wr;
  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic [15:0]       rd_data;

  assign ram_sel = ((d_addr >> RAM_AW) == 16'd0);
  assign io_sel  = (d_addr[15:4] == MMIO_BASE[15:4]) && !ram_sel;
  assign io_off  = d_addr[3:0];
  assign io_wr   = d_we && io_sel;

  // RAM is not reset. Its read is taken combinationally from the old
  // contents and registered into d_dout, which gives read-before-write.
  always_ff @(posedge clk) begin
    if (d_we && ram_sel)
      ram[d_addr[RAM_AW-1:0]] <= d_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_o  <= '0;
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      gpio_s1 <= gpio_i;
      gpio_s2 <= gpio_s1;
      if (io_wr && io_off == OFF_GPIO_OUT)
        gpio_o <= d_din[GPIO_W-1:0];
    end
  end

`ifdef YD_DBUS_TIMER_EN
  logic [15:0] tmr_ctrl;
  logic [15:0] tmr_cnt;
  logic [15:0] tmr_rld;
  logic        tmr_flag;
  logic [7:0]  psc;
  logic        tick;
  logic        wrap;
  logic        wr_ctrl;
  logic        wr_cnt;

  assign wr_ctrl = io_wr && io_off == OFF_TMR_CTRL;
  assign wr_cnt  = io_wr && io_off == OFF_TMR_CNT;

  // The prescaler is a down-counter. It is loaded with P when cleared and
  // ticks at terminal count 0, which gives one tick every P+1 cycles.
  assign tick = tmr_ctrl[0] && (psc == 8'd0);
  // A core write to CNT overrides a tick in the same cycle. That tick is
  // dropped entirely, so it sets no flag and does not self-disable the timer.
  assign wrap = tick && (tmr_cnt == 16'hFFFF) && !wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_ctrl <= '0;
      tmr_cnt  <= '0;
      tmr_rld  <= '0;
      tmr_flag <= 1'b0;
      psc      <= '0;
      tmr_irq  <= 1'b0;
    end else begin
      if (wr_ctrl)
        psc <= d_din[15:8];
      else if (!tmr_ctrl[0] || tick)
        psc <= tmr_ctrl[15:8];
      else
        psc <= psc - 8'd1;

      if (wr_ctrl)
        tmr_ctrl <= {d_din[15:8], 5'b0, d_din[2:0]};
      else if (wrap && !tmr_ctrl[1])
        tmr_ctrl[0] <= 1'b0;

      if (wr_cnt)
        tmr_cnt <= d_din;
      else if (tick)
        tmr_cnt <= (tmr_cnt == 16'hFFFF) ? tmr_rld : tmr_cnt + 16'd1;

      if (io_wr && io_off == OFF_TMR_RLD)
        tmr_rld <= d_din;

      // A wrap flag set takes priority over a W1C in the same cycle.
      if (wrap)
        tmr_flag <= 1'b1;
      else if (io_wr && io_off == OFF_TMR_STAT && d_din[0])
        tmr_flag <= 1'b0;

      tmr_irq <= tmr_flag && tmr_ctrl[2];
    end
  end
`else
  assign tmr_irq = 1'b0;
`endif

  always_comb begin
    rd_data = 16'h0;
    if (ram_sel) begin
      rd_data = ram[d_addr[RAM_AW-1:0]];
    end else if (io_sel) begin
      case (io_off)
        OFF_GPIO_OUT: rd_data[GPIO_W-1:0] = gpio_o;
        OFF_GPIO_IN:  rd_data[GPIO_W-1:0] = gpio_s2;
`ifdef YD_DBUS_TIMER_EN
        OFF_TMR_CTRL: rd_data = tmr_ctrl;
        OFF_TMR_CNT:  rd_data = tmr_cnt;
        OFF_TMR_RLD:  rd_data = tmr_rld;
        OFF_TMR_STAT: rd_data = {15'h0, tmr_flag};
`endif
        default:      rd_data = 16'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      d_dout <= '0;
    else
      d_dout <= rd_data;
  end

endmodule

// File: tb/tb_yd_dbus_resp.sv
// Directed bench for yd_dbus_resp. Every expected value is computed by hand
// from the bus timing: d_dout is checked 1 time unit after the edge that
// registers the read.

module tb_yd_dbus_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_din = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_dout;
  logic [15:0] gpio_i = '0;
  logic [15:0] gpio_o;
  logic        tmr_irq;

  int n_err = 0;
  int n_chk = 0;

  yd_dbus_resp dut (
    .clk(clk), .rst_n(rst_n), .d_addr(d_addr), .d_din(d_din), .d_we(d_we),
    .d_dout(d_dout), .gpio_i(gpio_i), .gpio_o(gpio_o), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  // One bus cycle: present the inputs, take one rising edge, then settle 1 unit.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    d_addr = a;
    d_din  = d;
    d_we   = w;
    @(posedge clk);
    #1;
    d_we = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_dout", d_dout, 16'h0);
    check("rst_gpio_o", gpio_o, 16'h0);
    check("rst_irq", {15'h0, tmr_irq}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: RAM write then read
    cyc(16'h0010, 16'hA5C3, 1'b1);
    cyc(16'h0010, 16'h0, 1'b0);
    check("ram_rd", d_dout, 16'hA5C3);

    // 2: read-before-write on the same address
    cyc(16'h0005, 16'h0001, 1'b1);
    cyc(16'h0005, 16'h0002, 1'b1);
    check("raw_old", d_dout, 16'h0001);
    cyc(16'h0005, 16'h0, 1'b0);
    check("raw_new", d_dout, 16'h0002);

    // 3: decode -- out-of-range writes must not alias onto RAM[0]
    cyc(16'h0000, 16'h1111, 1'b1);
    cyc(16'h2000, 16'h1234, 1'b1);
    cyc(16'h2000, 16'h0, 1'b0);
    check("unmapped_rd", d_dout, 16'h0);
    cyc(16'hFF0F, 16'h0, 1'b0);
    check("io_unmapped", d_dout, 16'h0);
    cyc(16'h0000, 16'h0, 1'b0);
    check("ram0_kept", d_dout, 16'h1111);
    cyc(16'h0FFF, 16'hCAFE, 1'b1);
    cyc(16'h0FFF, 16'h0, 1'b0);
    check("ram_top", d_dout, 16'hCAFE);

    // 4: GPIO
    cyc(16'hFF00, 16'h00F0, 1'b1);
    check("gpio_o", gpio_o, 16'h00F0);
    cyc(16'hFF00, 16'h0, 1'b0);
    check("gpio_out_rd", d_dout, 16'h00F0);
    gpio_i = 16'h0003;
    cyc(16'hFF01, 16'h0, 1'b0);
    check("gpio_in_sync1", d_dout, 16'h0000);
    cyc(16'h0000, 16'h0, 1'b0);
    cyc(16'hFF01, 16'h0, 1'b0);
    check("gpio_in", d_dout, 16'h0003);

`ifdef YD_DBUS_TIMER_EN
    // 5: P=1 autoreload with irq enabled. The write to CTRL is edge E0.
    cyc(16'hFF04, 16'hFFFE, 1'b1);
    cyc(16'hFF03, 16'hFFFE, 1'b1);
    cyc(16'hFF02, 16'h0107, 1'b1);
    repeat (4) cyc(16'h0000, 16'h0, 1'b0);        // E1..E4, wrap lands at E4
    check("irq_lag", {15'h0, tmr_irq}, 16'h0);
    cyc(16'hFF03, 16'h0, 1'b0);                   // E5
    check("cnt_reloaded", d_dout, 16'hFFFE);
    check("irq_set", {15'h0, tmr_irq}, 16'h1);
    cyc(16'hFF02, 16'h0104, 1'b1);                // E6: tick FFFE->FFFF, stop
    cyc(16'hFF05, 16'h0, 1'b0);
    check("flag_set", d_dout, 16'h0001);
    cyc(16'hFF05, 16'h0001, 1'b1);                // W1C
    cyc(16'hFF03, 16'h0, 1'b0);
    check("cnt_frozen", d_dout, 16'hFFFF);
    check("irq_clr", {15'h0, tmr_irq}, 16'h0);
    cyc(16'hFF05, 16'h0, 1'b0);
    check("flag_clr", d_dout, 16'h0000);

    // 6: one-shot with P=0 wraps on its first tick and self-disables
    cyc(16'hFF02, 16'h0005, 1'b1);
    cyc(16'hFF02, 16'h0, 1'b0);
    check("ctrl_rd", d_dout, 16'h0005);
    cyc(16'hFF02, 16'h0, 1'b0);
    check("oneshot_off", d_dout, 16'h0004);
    check("oneshot_irq", {15'h0, tmr_irq}, 16'h1);
    cyc(16'hFF03, 16'h0, 1'b0);
    check("oneshot_cnt", d_dout, 16'hFFFE);

    // Start a slow count (P=255) so that reset lands mid-count with irq high.
    cyc(16'hFF00, 16'hBEEF, 1'b1);
    cyc(16'hFF02, 16'hFF05, 1'b1);
    cyc(16'hFF00, 16'h0, 1'b0);
    check("pre_rst_dout", d_dout, 16'hBEEF);
    check("pre_rst_irq", {15'h0, tmr_irq}, 16'h1);
`else
    // Without the timer, offsets 2-5 are inert.
    cyc(16'hFF03, 16'h1234, 1'b1);
    cyc(16'hFF03, 16'h0, 1'b0);
    check("no_tmr_cnt", d_dout, 16'h0);
    cyc(16'hFF02, 16'h0007, 1'b1);
    repeat (3) cyc(16'h0000, 16'h0, 1'b0);
    cyc(16'hFF02, 16'h0, 1'b0);
    check("no_tmr_ctrl", d_dout, 16'h0);
    check("no_tmr_irq", {15'h0, tmr_irq}, 16'h0);
    cyc(16'hFF00, 16'hBEEF, 1'b1);
    cyc(16'hFF00, 16'h0, 1'b0);
    check("pre_rst_dout", d_dout, 16'hBEEF);
`endif

    // Asynchronous reset away from a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", d_dout, 16'h0);
    check("arst_gpio_o", gpio_o, 16'h0);
    check("arst_irq", {15'h0, tmr_irq}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(16'h0010, 16'h0, 1'b0);
    check("ram_survives_rst", d_dout, 16'hA5C3);
    cyc(16'hFF00, 16'h0, 1'b0);
    check("gpio_after_rst", d_dout, 16'h0);
    cyc(16'hFF03, 16'h0, 1'b0);
    check("cnt_after_rst", d_dout, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
